dma_controller: RTL and testbench

Bus-mastering DMA engine sitting directly downstream of the CPU's DMA command interface. Accepts a one-cycle `begin_dma` command carrying a target address and word count, and requests the memory bus with `br`. Once granted (`bg`), it copies the external device buffer into memory one 64-bit line at a time. It then releases the bus and reports completion with a one-cycle `dma_end` pulse.

---
 rtl/dma_pkg.sv | 39 +++
 rtl/dma_mask_gen.sv | 26 ++
 rtl/dma_controller.sv | 166 ++++++++++++++++
 tb/tb_dma_controller.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// -----------------------------------------------------------------------------
// dma_pkg
// Shared constants, types and helpers for the bus-mastering DMA engine.
//
//   WORD_SIZE  : address and data word width (16)
//   LINE_WORDS : words per memory line (4, i.e. a 64-bit line)
//   MAX_LINES  : lines addressable through the 4-bit device line index (16)
//   state_t    : controller FSM states
//   remain_t   : remaining-word counter, wide enough to hold MAX_WORDS
// -----------------------------------------------------------------------------
package dma_pkg;

  localparam int WORD_SIZE  = 16;
  localparam int LINE_WORDS = 4;
  localparam int MAX_LINES  = 16;

  localparam int LINE_BITS  = WORD_SIZE * LINE_WORDS;        // 64
  localparam int MAX_WORDS  = MAX_LINES * LINE_WORDS;        // 64
  localparam int REMAIN_W   = $clog2(MAX_WORDS + 1);         // 7
  localparam int INDEX_W    = $clog2(MAX_LINES);             // 4

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    XFER,
    RELEASE,
    END
  } state_t;

  typedef logic [REMAIN_W-1:0] remain_t;

  // The device line index is only INDEX_W bits wide, so longer requests are
  // truncated to the first MAX_WORDS words when the command is latched.
  function automatic remain_t clamp_length(input logic [WORD_SIZE-1:0] len);
    if (len > WORD_SIZE'(MAX_WORDS)) return remain_t'(MAX_WORDS);
    return remain_t'(len);
  endfunction

endpackage

// File: rtl/dma_mask_gen.sv
// -----------------------------------------------------------------------------
// dma_mask_gen
// Per-word write enable for one memory line, derived from the number of words
// still to be transferred. A full line is enabled when at least LINE_WORDS
// words remain; otherwise only the low `remain` words are enabled.
//
//   remain : in  REMAIN_W    words still to transfer (0..MAX_WORDS)
//   mask   : out LINE_WORDS  bit i enables word i of the line
// -----------------------------------------------------------------------------
module dma_mask_gen
  import dma_pkg::*;
(
  input  logic [REMAIN_W-1:0]   remain,
  output logic [LINE_WORDS-1:0] mask
);

  always_comb begin
    // NOTE: assigning a default before the loop guarantees every bit is driven
    // on every path, so no latch can be inferred.
    mask = '0;
    for (int i = 0; i < LINE_WORDS; i++) begin
      mask[i] = (remain > REMAIN_W'(i));
    end
  end

endmodule

// File: rtl/dma_controller.sv
// -----------------------------------------------------------------------------
// dma_controller
// Bus-mastering DMA engine. A one-cycle begin_dma command latches a target
// word address and a word count, requests the memory bus with br, and once
// granted copies the device buffer into memory one 64-bit line per
// mem_ready handshake. When the last line is acknowledged the bus is released
// and, after the grant drops, completion is signalled with a one-cycle dma_end.
//
//   clk            : in  1   system clock, all state on posedge
//   reset          : in  1   asynchronous, active-high
//   begin_dma      : in  1   command strobe (ignored unless idle)
//   target_address : in  16  first memory word address
//   length         : in  16  word count (clamped to 64)
//   br             : out 1   bus request
//   bg             : in  1   bus grant
//   dev_index      : out 4   line index into device buffer
//   dev_data       : in  64  device line at dev_index (combinational)
//   mem_write      : out 1   memory write request
//   mem_address    : out 16  word address of the line being written
//   mem_data       : out 64  line data, word 0 in bits [15:0]
//   mem_mask       : out 4   per-word write enable
//   mem_ready      : in  1   memory acknowledge for the current write
//   dma_end        : out 1   completion pulse
//   busy           : out 1   high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module dma_controller
  import dma_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  begin_dma,
  input  logic [WORD_SIZE-1:0]  target_address,
  input  logic [WORD_SIZE-1:0]  length,
  output logic                  br,
  input  logic                  bg,
  output logic [INDEX_W-1:0]    dev_index,
  input  logic [LINE_BITS-1:0]  dev_data,
  output logic                  mem_write,
  output logic [WORD_SIZE-1:0]  mem_address,
  output logic [LINE_BITS-1:0]  mem_data,
  output logic [LINE_WORDS-1:0] mem_mask,
  input  logic                  mem_ready,
  output logic                  dma_end,
  output logic                  busy
);

  state_t               state;
  logic [WORD_SIZE-1:0] addr_r;
  remain_t              remain_r;
  logic [INDEX_W-1:0]   line_r;

  // Bookkeeping for the line currently being written.
  remain_t              step;
  remain_t              remain_after;
  remain_t              mask_src;
  logic [LINE_WORDS-1:0] mask_next;
  logic [WORD_SIZE-1:0] addr_next;
  logic [INDEX_W-1:0]   line_next;

  assign step         = (remain_r >= remain_t'(LINE_WORDS)) ? remain_t'(LINE_WORDS) : remain_r;
  assign remain_after = remain_r - step;
  assign addr_next    = addr_r + WORD_SIZE'(LINE_WORDS);   // wraps modulo 2^16
  assign line_next    = line_r + INDEX_W'(1);

  // mem_mask is registered, so it is computed for the line that will be on
  // the bus next cycle: the current remainder when entering XFER from REQ,
  // or the post-acknowledge remainder for a back-to-back line.
  assign mask_src = (state == XFER) ? remain_after : remain_r;

  dma_mask_gen u_mask_gen (
    .remain (mask_src),
    .mask   (mask_next)
  );

  // The only combinational output: the device line passes straight through
  // while a write is on the bus and is forced to zero otherwise.
  assign mem_data = mem_write ? dev_data : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      addr_r      <= '0;
      remain_r    <= '0;
      line_r      <= '0;
      br          <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_mask    <= '0;
      dev_index   <= '0;
      dma_end     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      dma_end <= 1'b0;

      unique case (state)
        IDLE: begin
          if (begin_dma) begin
            addr_r      <= target_address;
            remain_r    <= clamp_length(length);
            line_r      <= '0;
            mem_address <= target_address;
            dev_index   <= '0;
            busy        <= 1'b1;
            if (length == '0) begin
              // Nothing to move: skip the bus entirely.
              state   <= END;
              dma_end <= 1'b1;
            end else begin
              state <= REQ;
              br    <= 1'b1;
            end
          end
        end

        REQ: begin
          if (bg) begin
            state     <= XFER;
            mem_write <= 1'b1;
            mem_mask  <= mask_next;
          end
        end

        XFER: begin
          // Outputs hold until the memory acknowledges; a grant drop in the
          // middle of a write is honoured only after the write completes.
          if (mem_ready) begin
            addr_r      <= addr_next;
            line_r      <= line_next;
            remain_r    <= remain_after;
            mem_address <= addr_next;
            dev_index   <= line_next;
            if (remain_after == '0) begin
              state     <= RELEASE;
              br        <= 1'b0;
              mem_write <= 1'b0;
              mem_mask  <= '0;
            end else if (!bg) begin
              state     <= REQ;
              mem_write <= 1'b0;
              mem_mask  <= '0;
            end else begin
              mem_mask <= mask_next;
            end
          end
        end

        RELEASE: begin
          if (!bg) begin
            state   <= END;
            dma_end <= 1'b1;
          end
        end

        END: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_controller.sv
// -----------------------------------------------------------------------------
// tb_dma_controller
// Self-checking bench for dma_controller. A transaction-level model turns each
// accepted command into the list of line writes it must produce; a monitor
// compares every bus cycle against the head of that list. Bus arbiter and
// memory are small reactive processes with programmable delays.
// -----------------------------------------------------------------------------
module tb_dma_controller;
  import dma_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        begin_dma;
  logic [15:0] target_address;
  logic [15:0] length;
  logic        br;
  logic        bg;
  logic [3:0]  dev_index;
  logic [63:0] dev_data;
  logic        mem_write;
  logic [15:0] mem_address;
  logic [63:0] mem_data;
  logic [3:0]  mem_mask;
  logic        mem_ready;
  logic        dma_end;
  logic        busy;

  logic [63:0] dev_buf [16];
  assign dev_data = dev_buf[dev_index];

  always #5 clk = ~clk;

  dma_controller dut (
    .clk            (clk),
    .reset          (reset),
    .begin_dma      (begin_dma),
    .target_address (target_address),
    .length         (length),
    .br             (br),
    .bg             (bg),
    .dev_index      (dev_index),
    .dev_data       (dev_data),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_data       (mem_data),
    .mem_mask       (mem_mask),
    .mem_ready      (mem_ready),
    .dma_end        (dma_end),
    .busy           (busy)
  );

  typedef struct {
    logic [15:0] addr;
    logic [3:0]  idx;
    logic [3:0]  mask;
  } wr_t;

  wr_t exp_q[$];     // model: writes still owed by the DUT
  wr_t log_q[$];     // DUT writes observed at acknowledge

  int n_checks = 0;
  int n_pass   = 0;
  int dma_end_seen  = 0;
  int ends_expected = 0;
  int grant_delay   = 1;
  int ready_delay   = 1;
  bit hold_off      = 1'b0;
  bit br_seen       = 1'b0;
  bit mw_seen       = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Model: a command of len words at tgt becomes ceil(min(len,64)/4) line
  // writes at consecutive 4-word addresses, last line partially enabled.
  task automatic push_cmd(input logic [15:0] tgt, input logic [15:0] len);
    int words = (len > 16'd64) ? 64 : int'(len);
    int done  = 0;
    int line  = 0;
    while (done < words) begin
      int  n = (words - done >= 4) ? 4 : words - done;
      wr_t w;
      w.addr = tgt + 16'(4 * line);
      w.idx  = 4'(line);
      w.mask = 4'((1 << n) - 1);
      exp_q.push_back(w);
      done += n;
      line++;
    end
  endtask

  task automatic issue(input logic [15:0] tgt, input logic [15:0] len);
    @(posedge clk); #2;
    target_address = tgt;
    length         = len;
    begin_dma      = 1'b1;
    @(posedge clk); #2;
    begin_dma      = 1'b0;
    target_address = 16'($urandom);
    length         = 16'($urandom);
  endtask

  task automatic wait_end(input int target, input int budget);
    int n = 0;
    while (dma_end_seen < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("dma_end_count", 64'(dma_end_seen), 64'(target));
  endtask

  task automatic wait_for_write(input logic [15:0] addr, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(mem_write && mem_address == addr) && n < budget);
    check("reach_write", 64'({mem_write, mem_address}), 64'({1'b1, addr}));
  endtask

  task automatic check_idle_after_end();
    @(negedge clk);
    check("busy_after_end", 64'(busy), 64'd0);
    check("br_after_end", 64'(br), 64'd0);
  endtask

  // Bus arbiter: grants grant_delay cycles after a request, drops the grant
  // once the request is withdrawn or while hold_off is set.
  initial begin
    int cnt;
    cnt = 0;
    bg  = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (!br || hold_off) begin
        bg  = 1'b0;
        cnt = 0;
      end else if (!bg) begin
        if (cnt >= grant_delay) bg = 1'b1;
        else cnt++;
      end
    end
  end

  // Memory: acknowledges each line after ready_delay wait cycles.
  initial begin
    int cnt;
    cnt       = 0;
    mem_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (mem_ready) cnt = 0;
      mem_ready = 1'b0;
      if (mem_write && !reset) begin
        if (cnt >= ready_delay) mem_ready = 1'b1;
        else cnt++;
      end else begin
        cnt = 0;
      end
    end
  end

  // Compare process: every cycle, checked mid-cycle against the model.
  initial begin
    bit  prev_end;
    wr_t w;
    prev_end = 1'b0;
    forever begin
      @(negedge clk);
      if (br) br_seen = 1'b1;
      if (mem_write) mw_seen = 1'b1;
      if (br) check("busy_with_br", 64'(busy), 64'd1);
      if (mem_write) begin
        check("write_expected", 64'(exp_q.size() != 0), 64'd1);
        check("br_during_write", 64'(br), 64'd1);
        if (exp_q.size() != 0) begin
          check("mem_address", 64'(mem_address), 64'(exp_q[0].addr));
          check("dev_index", 64'(dev_index), 64'(exp_q[0].idx));
          check("mem_mask", 64'(mem_mask), 64'(exp_q[0].mask));
          check("mem_data", mem_data, dev_buf[exp_q[0].idx]);
          if (mem_ready) begin
            w.addr = mem_address;
            w.idx  = dev_index;
            w.mask = mem_mask;
            log_q.push_back(w);
            void'(exp_q.pop_front());
          end
        end
      end else begin
        check("mask_idle", 64'(mem_mask), 64'd0);
        check("data_idle", mem_data, 64'd0);
      end
      if (dma_end) begin
        dma_end_seen++;
        check("end_single_cycle", 64'(prev_end), 64'd0);
        check("end_bus_released", 64'({br, mem_write}), 64'd0);
        check("writes_done_at_end", 64'(exp_q.size()), 64'd0);
      end
      prev_end = dma_end;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ends_before;
    int cycles;

    for (int i = 0; i < 16; i++) dev_buf[i] = {32'($urandom), 32'($urandom)};
    reset          = 1'b1;
    begin_dma      = 1'b0;
    target_address = '0;
    length         = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_br", 64'(br), 64'd0);
    check("rst_mem_write", 64'(mem_write), 64'd0);
    check("rst_mem_address", 64'(mem_address), 64'd0);
    check("rst_mem_mask", 64'(mem_mask), 64'd0);
    check("rst_mem_data", mem_data, 64'd0);
    check("rst_dev_index", 64'(dev_index), 64'd0);
    check("rst_dma_end", 64'(dma_end), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #3;
    reset = 1'b0;

    // Full-line transfer
    grant_delay = 1; ready_delay = 1;
    log_q.delete();
    push_cmd(16'h000B, 16'd12);
    check("model_lines_12", 64'(exp_q.size()), 64'd3);
    check("model_addr_1", 64'(exp_q[1].addr), 64'h000F);
    check("model_addr_2", 64'(exp_q[2].addr), 64'h0013);
    check("model_mask_2", 64'(exp_q[2].mask), 64'hF);
    ends_expected++;
    issue(16'h000B, 16'd12);
    @(negedge clk);
    check("br_next_cycle", 64'(br), 64'd1);
    check("no_write_before_grant", 64'(mem_write), 64'd0);
    wait_end(ends_expected, 200);
    check("t1_writes", 64'(log_q.size()), 64'd3);
    if (log_q.size() == 3) begin
      check("t1_addr0", 64'(log_q[0].addr), 64'h000B);
      check("t1_addr1", 64'(log_q[1].addr), 64'h000F);
      check("t1_addr2", 64'(log_q[2].addr), 64'h0013);
      check("t1_idx2", 64'(log_q[2].idx), 64'd2);
      check("t1_mask1", 64'(log_q[1].mask), 64'hF);
    end
    check_idle_after_end();

    // Partial last line
    log_q.delete();
    push_cmd(16'h0020, 16'd6);
    check("model_mask_6", 64'(exp_q[1].mask), 64'h3);
    ends_expected++;
    issue(16'h0020, 16'd6);
    wait_end(ends_expected, 200);
    check("t2_writes", 64'(log_q.size()), 64'd2);
    if (log_q.size() == 2) begin
      check("t2_addr1", 64'(log_q[1].addr), 64'h0024);
      check("t2_mask0", 64'(log_q[0].mask), 64'hF);
      check("t2_mask1", 64'(log_q[1].mask), 64'h3);
    end
    check_idle_after_end();

    // Zero length
    br_seen = 1'b0; mw_seen = 1'b0;
    ends_expected++;
    issue(16'h1234, 16'd0);
    @(negedge clk);
    check("zero_end_next_cycle", 64'(dma_end), 64'd1);
    check("zero_busy", 64'(busy), 64'd1);
    @(negedge clk);
    check("zero_end_one_cycle", 64'(dma_end), 64'd0);
    check("zero_idle", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    check("zero_no_br", 64'(br_seen), 64'd0);
    check("zero_no_write", 64'(mw_seen), 64'd0);
    check("zero_end_count", 64'(dma_end_seen), 64'(ends_expected));

    // Short partial lines, immediate grant and zero-wait memory
    grant_delay = 0; ready_delay = 0;
    log_q.delete();
    push_cmd(16'h0040, 16'd3);
    ends_expected++;
    issue(16'h0040, 16'd3);
    wait_end(ends_expected, 100);
    if (log_q.size() == 1) check("len3_mask", 64'(log_q[0].mask), 64'h7);
    else check("len3_writes", 64'(log_q.size()), 64'd1);
    log_q.delete();
    push_cmd(16'h0050, 16'd5);
    check("model_mask_5", 64'(exp_q[1].mask), 64'h1);
    ends_expected++;
    issue(16'h0050, 16'd5);
    wait_end(ends_expected, 100);
    if (log_q.size() == 2) check("len5_mask1", 64'(log_q[1].mask), 64'h1);
    else check("len5_writes", 64'(log_q.size()), 64'd2);
    check_idle_after_end();

    // Minimum latency: 2 lines, begin_dma cycle counted as cycle 1
    push_cmd(16'h0060, 16'd8);
    ends_expected++;
    issue(16'h0060, 16'd8);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!dma_end && cycles < 30);
    check("min_latency_cycles", 64'(cycles), 64'd5);
    wait_end(ends_expected, 10);

    // Grant/acknowledge delays with an ignored second command
    grant_delay = 5; ready_delay = 3;
    log_q.delete();
    push_cmd(16'h0100, 16'd10);
    ends_expected++;
    issue(16'h0100, 16'd10);
    wait_for_write(16'h0104, 100);
    issue(16'h5555, 16'd2);
    wait_end(ends_expected, 300);
    check("t4_writes", 64'(log_q.size()), 64'd3);
    if (log_q.size() == 3) begin
      check("t4_addr2", 64'(log_q[2].addr), 64'h0108);
      check("t4_mask2", 64'(log_q[2].mask), 64'h3);
    end
    check_idle_after_end();

    // Grant drop during the second of three writes
    grant_delay = 1; ready_delay = 2;
    log_q.delete();
    push_cmd(16'h000B, 16'd12);
    ends_expected++;
    issue(16'h000B, 16'd12);
    wait_for_write(16'h000F, 100);
    hold_off = 1'b1;
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (mem_write && cycles < 20);
    repeat (3) begin
      check("pause_br", 64'(br), 64'd1);
      check("pause_no_write", 64'(mem_write), 64'd0);
      check("pause_busy", 64'(busy), 64'd1);
      @(negedge clk);
    end
    check("pause_writes_done", 64'(log_q.size()), 64'd2);
    hold_off = 1'b0;
    wait_end(ends_expected, 200);
    check("t5_writes", 64'(log_q.size()), 64'd3);
    if (log_q.size() == 3) begin
      check("t5_resume_addr", 64'(log_q[2].addr), 64'h0013);
      check("t5_resume_idx", 64'(log_q[2].idx), 64'd2);
    end

    // Over-long request with address wrap
    grant_delay = 0; ready_delay = 0;
    log_q.delete();
    push_cmd(16'hFFF0, 16'd70);
    check("model_lines_70", 64'(exp_q.size()), 64'd16);
    check("model_wrap_addr", 64'(exp_q[15].addr), 64'h002C);
    ends_expected++;
    issue(16'hFFF0, 16'd70);
    wait_end(ends_expected, 200);
    check("t6_writes", 64'(log_q.size()), 64'd16);
    if (log_q.size() == 16) begin
      check("t6_wrap_addr", 64'(log_q[15].addr), 64'h002C);
      check("t6_last_idx", 64'(log_q[15].idx), 64'd15);
    end
    check_idle_after_end();

    // Reset mid-transfer
    grant_delay = 1; ready_delay = 3;
    push_cmd(16'h0200, 16'd12);
    issue(16'h0200, 16'd12);
    wait_for_write(16'h0200, 100);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check("async_rst_br", 64'(br), 64'd0);
    check("async_rst_write", 64'(mem_write), 64'd0);
    check("async_rst_busy", 64'(busy), 64'd0);
    exp_q.delete();
    ends_before = dma_end_seen;
    @(posedge clk); #3;
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_no_end", 64'(dma_end_seen), 64'(ends_before));
    log_q.delete();
    push_cmd(16'h0300, 16'd4);
    ends_expected = ends_before + 1;
    issue(16'h0300, 16'd4);
    wait_end(ends_expected, 200);
    check("t7_writes", 64'(log_q.size()), 64'd1);
    if (log_q.size() == 1) begin
      check("t7_addr", 64'(log_q[0].addr), 64'h0300);
      check("t7_mask", 64'(log_q[0].mask), 64'hF);
    end
    check_idle_after_end();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
